// File: rtl/ac_out_port_if.sv
// ac_out_port_if: bundles the controller push side and the external-device
// drain side of the AC output port.
//   slave modport  : used by ac_out_port itself
//   master modport : used by whoever drives the port (controller + device)
// Signals:
//   Din, OUTload       push data / push request from the controller
//   full, empty, count FIFO occupancy status
//   out_data/out_valid head-of-FIFO value towards the device
//   out_ready          device accepts out_data this cycle
//   drop_cnt           rejected-push counter (zero when the feature is off)
interface ac_out_port_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] Din;
  logic             OUTload;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       drop_cnt;

  modport slave (
    input  Din, OUTload, out_ready,
    output full, empty, count, out_data, out_valid, drop_cnt
  );

  modport master (
    output Din, OUTload, out_ready,
    input  full, empty, count, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/ac_out_port.sv
// ac_out_port: output port that queues accumulator values in a small FIFO and
// drains them to an external device over a valid/ready handshake.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset, clears all state including storage
//   bus  ac_out_port_if.slave (push side, status, drain side, drop_cnt)
// Optional feature: define ACOUT_DROP_CNT_EN to build a saturating counter of
// pushes rejected because the FIFO was full; otherwise drop_cnt reads 0.
module ac_out_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  ac_out_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  // Status comes from the registered count so the controller sees a clean,
  // edge-aligned full flag.
  assign bus.full      = (count_q == (AW+1)'(DEPTH));
  assign bus.empty     = (count_q == '0);
  assign bus.out_valid = !bus.empty;
  assign bus.count     = count_q;
  assign bus.out_data  = mem[rd_ptr];

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push = bus.OUTload && !bus.full;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.Din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ACOUT_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (bus.OUTload && bus.full && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_ac_out_port.sv
module tb_ac_out_port;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef ACOUT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ac_out_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  ac_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // reference model: queue of pending values plus rejected-push tally
  logic [7:0] q[$];
  int         drops;
  bit         fresh;   // nothing pushed since reset -> storage still all zero

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    int n;
    n = q.size();
    check("count", 32'(bus.count), 32'(n));
    check("full", 32'(bus.full), 32'(n == DEPTH));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("out_valid", 32'(bus.out_valid), 32'(n != 0));
    check("drop_cnt", 32'(bus.drop_cnt), 32'(DROP_EN ? drops : 0));
    if (n != 0) check("out_data", 32'(bus.out_data), 32'(q[0]));
    else if (fresh) check("out_data_rst", 32'(bus.out_data), 32'h0);
  endtask

  // drive one cycle, advance the model by the same rules, then compare
  task automatic step(input bit r, input bit ld, input logic [7:0] d, input bit rdy);
    bit acc;
    bit popd;
    rst = r;
    bus.OUTload = ld;
    bus.Din = d;
    bus.out_ready = rdy;
    if (r) begin
      q.delete();
      drops = 0;
      fresh = 1'b1;
    end else begin
      acc  = ld && (q.size() < DEPTH);
      popd = rdy && (q.size() > 0);
      if (ld && !acc && drops < 255) drops++;
      if (popd) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        fresh = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    verify();
  endtask

  initial begin
    int idx;
    int guard;
    rst = 1'b1;
    bus.OUTload = 1'b0;
    bus.Din = '0;
    bus.out_ready = 1'b0;
    drops = 0;
    fresh = 1'b1;

    // reset and single transfer
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);

    // fill, overflow twice, drain in order
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h05, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

    // simultaneous push/pop at count 2, then at count 4
    step(0, 1, 8'h20, 0);
    step(0, 1, 8'h21, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h33, 1);
    step(0, 1, 8'h44, 0);
    step(0, 1, 8'h45, 0);
    step(0, 1, 8'h99, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

    // wrap-around stream with random backpressure
    idx = 0;
    guard = 0;
    while ((idx < 10 || q.size() != 0) && guard < 300) begin
      bit ld;
      ld = (idx < 10) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      step(0, ld, 8'(8'h10 + idx), 1'($urandom_range(0, 1)));
      if (ld) idx++;
      guard++;
    end
    check("stream_done", 32'(guard < 300), 32'd1);

    // random mixed traffic, including pushes against a full FIFO
    for (int i = 0; i < 120; i++)
      step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));

    // reset mid-operation with a push and pop pending
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(1, 1, 8'h77, 1);
    step(0, 0, 8'h00, 0);

    // drop counter saturation
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 300; i++) step(0, 1, 8'($urandom), 0);
    check("drop_sat", 32'(bus.drop_cnt), DROP_EN ? 32'd255 : 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
